// File: rtl/cache_line_arbiter.sv
// Round-robin arbiter sequencing I-cache line fills and D-cache fills/writebacks
// onto a single line-wide memory port; every memory-side output is registered.
module cache_line_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_read,
    input  logic [ADDR_W-1:0] ic_address,
    output logic [LINE_W-1:0] ic_rdata,
    output logic              ic_resp,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_address,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              dc_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [2:0] {
        IDLE,
        MEM_I,
        MEM_D,
        RESP_I,
        RESP_D
    } state_e;

    state_e            state_q;
    logic              last_grant_q;  // 0 = I-side granted last, 1 = D-side
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [LINE_W-1:0] mem_wdata_q;
    logic [LINE_W-1:0] rdata_q;
    logic              ic_resp_q;
    logic              dc_resp_q;

    logic i_req;
    logic d_req;
    logic grant_d;

    assign i_req   = ic_read;
    assign d_req   = dc_read | dc_write;
    // Under contention the side opposite the previous grant wins.
    assign grant_d = d_req && (!i_req || !last_grant_q);

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order inside the block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            rdata_q       <= '0;
            ic_resp_q     <= 1'b0;
            dc_resp_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        last_grant_q  <= grant_d;
                        mem_address_q <= grant_d ? dc_address : ic_address;
                        // A simultaneous dc_read/dc_write is resolved as a write.
                        mem_write_q   <= grant_d && dc_write;
                        mem_read_q    <= grant_d ? !dc_write : 1'b1;
                        if (grant_d && dc_write) begin
                            mem_wdata_q <= dc_wdata;
                        end
                        state_q       <= grant_d ? MEM_D : MEM_I;
                    end
                end
                MEM_I, MEM_D: begin
                    if (mem_resp) begin
                        rdata_q     <= mem_rdata;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        ic_resp_q   <= (state_q == MEM_I);
                        dc_resp_q   <= (state_q == MEM_D);
                        state_q     <= (state_q == MEM_I) ? RESP_I : RESP_D;
                    end
                end
                RESP_I, RESP_D: begin
                    ic_resp_q <= 1'b0;
                    dc_resp_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign ic_rdata    = rdata_q;
    assign dc_rdata    = rdata_q;
    assign ic_resp     = ic_resp_q;
    assign dc_resp     = dc_resp_q;

endmodule
